// File: rtl/clk_div_meas_pkg.sv
// Shared types for the clock-under-test measurement block.
//   clk_meas_state_e : measurement FSM state encoding
package clk_div_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } clk_meas_state_e;

endpackage

// File: rtl/clk_div_meas_sync_ff.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
// STAGES = 0 turns the chain into a wire for a CUT already in the clk domain.
// Ports:
//   clk   : sampling clock
//   rst_n : synchronous active-low reset, clears the chain
//   d     : asynchronous input level
//   q     : synchronized level
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/clk_div_meas.sv
// Measures a clock under test (CUT), sampled as data, in clk_i cycles:
// rise-to-rise period and rise-to-fall high time. Flags lock once the
// waveform repeats LOCK_CNT times and pulses err_o when the CUT stops.
// Ports:
//   clk_i     : measurement clock
//   rst_ni    : synchronous active-low reset
//   clk_div_i : clock under test
//   period_o  : last measured period
//   high_o    : last measured high time
//   valid_o   : period_o holds a full measurement
//   lock_o    : LOCK_CNT consecutive equal (period, high) pairs seen
//   err_o     : one-cycle timeout pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first CUT rise; period counter frozen at 0
// MEASURE | measuring; fewer than LOCK_CNT consecutive matches so far
// LOCKED  | LOCK_CNT consecutive matching measurements; lock_o high
module clk_div_meas
  import clk_div_meas_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clk_div_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 lock_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam int                   MCNT_W  = $clog2(LOCK_CNT + 1);
  localparam logic [MCNT_W-1:0]    MCNT_FULL = MCNT_W'(LOCK_CNT);
  localparam logic [MCNT_W-1:0]    MCNT_ONE  = MCNT_W'(1);

  clk_meas_state_e state, state_nxt;

  logic                 s, s_q;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] pcnt, hcnt;
  logic [CNT_WIDTH-1:0] period_nxt, high_nxt;
  logic [CNT_WIDTH-1:0] high_snap, high_snap_nxt;
  logic [MCNT_W-1:0]    mcnt, mcnt_nxt;
  logic                 valid_nxt, err_nxt;
  logic                 match;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (clk_div_i),
    .q     (s)
  );

  // Edge pulses are registered; s_q is then the CUT level aligned with
  // rise/fall, which is what the high counter has to follow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_q  <= s;
      rise <= s & ~s_q;
      fall <= ~s & s_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcnt <= '0;
      hcnt <= '0;
    end else begin
      if (rise) begin
        pcnt <= CNT_ONE;
      end else if (state == IDLE) begin
        pcnt <= '0;
      end else if (pcnt != CNT_MAX) begin
        pcnt <= pcnt + CNT_ONE;
      end

      if (rise) begin
        hcnt <= CNT_ONE;
      end else if (s_q && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      mcnt      <= '0;
      high_snap <= '0;
    end else begin
      state     <= state_nxt;
      period_o  <= period_nxt;
      high_o    <= high_nxt;
      valid_o   <= valid_nxt;
      err_o     <= err_nxt;
      mcnt      <= mcnt_nxt;
      high_snap <= high_snap_nxt;
    end
  end

  // high_snap remembers high_o as it was at the previous rise, so a duty
  // change alone (same period) still breaks the match run.
  assign match = (pcnt == period_o) && (high_o == high_snap);

  always_comb begin
    state_nxt     = state;
    period_nxt    = period_o;
    high_nxt      = high_o;
    valid_nxt     = valid_o;
    err_nxt       = 1'b0;
    mcnt_nxt      = mcnt;
    high_snap_nxt = high_snap;

    if (rise) begin
      high_snap_nxt = high_o;
    end

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        if (fall) begin
          high_nxt = hcnt;
        end
        // A rise on the saturation cycle is a valid max-length measurement.
        if (rise) begin
          period_nxt = pcnt;
          valid_nxt  = 1'b1;
          if (!match) begin
            mcnt_nxt = '0;
          end else if (mcnt != MCNT_FULL) begin
            mcnt_nxt = mcnt + MCNT_ONE;
          end
          state_nxt = (mcnt_nxt == MCNT_FULL) ? LOCKED : MEASURE;
        end else if (pcnt == CNT_MAX) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          mcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign lock_o = (state == LOCKED);

endmodule
